// File: rtl/div_pkg.sv
// Shared types and constants for the restoring divider.
// Pure declarations; no latency, no backpressure.
// Imported by the divider top.
package div_pkg;

    localparam int DIV_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } div_state_e;

    // Wide enough for any supported WIDTH; the top slices the width it needs.
    localparam logic [63:0] DIV_ZERO_ALL_ONES = '1;

endpackage

// File: rtl/restoring_divider_16_borrow_subtractor.sv
// Ripple-borrow subtractor built from full-subtractor cells: diff = a - b - bin.
// Combinational, zero latency.
// No handshake; the result follows the inputs.
module borrow_subtractor #(
    parameter int N = 17
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         bin,
    output logic [N-1:0] diff,
    output logic         bout
);

    logic [N:0] bchain;

    assign bchain[0] = bin;

    for (genvar i = 0; i < N; i++) begin : g_cell
        assign diff[i]     = a[i] ^ b[i] ^ bchain[i];
        assign bchain[i+1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & bchain[i]);
    end

    assign bout = bchain[N];

endmodule

// File: rtl/restoring_divider_16.sv
// Sequential unsigned restoring divider, one quotient bit per cycle.
// Latency: WIDTH cycles from accept to out_valid (1 cycle for divide by zero).
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE.
module restoring_divider_16
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             busy
);

    localparam int              CW      = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] DZ_QUOT = DIV_ZERO_ALL_ONES[WIDTH-1:0];

    div_state_e       state, state_nxt;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] dvsr_q;
    logic             dbz_q;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic             bout;
    logic             trial_fail;

    assign shifted = {rem_q, quo_q[WIDTH-1]};

    borrow_subtractor #(
        .N(WIDTH + 1)
    ) u_sub (
        .a   (shifted),
        .b   ({1'b0, dvsr_q}),
        .bin (1'b0),
        .diff(diff),
        .bout(bout)
    );

    // Difference MSB and ripple borrow-out coincide for in-range operands.
    assign trial_fail = diff[WIDTH] | bout;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    state_nxt = (divisor == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (count == '0) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count  <= '0;
            rem_q  <= '0;
            quo_q  <= '0;
            dvsr_q <= '0;
            dbz_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        dvsr_q <= divisor;
                        count  <= CW'(WIDTH - 1);
                        if (divisor == '0) begin
                            quo_q <= DZ_QUOT;
                            rem_q <= dividend;
                            dbz_q <= 1'b1;
                        end else begin
                            quo_q <= dividend;
                            rem_q <= '0;
                            dbz_q <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    if (count != '0) begin
                        count <= count - 1'b1;
                    end
                    quo_q <= {quo_q[WIDTH-2:0], ~trial_fail};
                    rem_q <= trial_fail ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
                end
                DONE: begin
                    if (out_ready) begin
                        dbz_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready    = (state == IDLE);
    assign out_valid   = (state == DONE);
    assign busy        = (state == RUN) || (state == DONE);
    assign quotient    = quo_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_restoring_divider_16.sv
// Directed bench for restoring_divider_16 with hand-computed results.
module tb_restoring_divider_16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] dividend;
    logic [15:0] divisor;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        div_by_zero;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    restoring_divider_16 #(.WIDTH(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .dividend   (dividend),
        .divisor    (divisor),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // Entered and left at a negedge. elat counts clock edges after the accept
    // edge until out_valid is seen; hold = cycles of out_ready low in DONE.
    task automatic run_op(input logic [15:0] dvd, input logic [15:0] dvs,
                          input logic [15:0] eq, input logic [15:0] er,
                          input logic edbz, input int elat, input int hold);
        int lat;
        out_ready = (hold == 0);
        in_valid  = 1'b1;
        dividend  = dvd;
        divisor   = dvs;
        check_eq("in_ready_before_accept", in_ready, 1);
        @(posedge clk);
        @(negedge clk);
        // Garbage with in_valid high must be ignored while busy.
        dividend = 16'hDEAD;
        divisor  = 16'h0003;
        if (elat > 0) begin
            check_eq("busy_in_run", busy, 1);
            check_eq("in_ready_in_run", in_ready, 0);
        end
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        check_eq("latency", lat, elat);
        check_eq("out_valid", out_valid, 1);
        check_eq("quotient", quotient, eq);
        check_eq("remainder", remainder, er);
        check_eq("div_by_zero", div_by_zero, edbz);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            @(negedge clk);
            check_eq("hold_valid", out_valid, 1);
            check_eq("hold_quotient", quotient, eq);
            check_eq("hold_remainder", remainder, er);
            check_eq("hold_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_eq("valid_drops", out_valid, 0);
        check_eq("dbz_clears", div_by_zero, 0);
        check_eq("in_ready_after", in_ready, 1);
        check_eq("busy_after", busy, 0);
        in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        dividend  = '0;
        divisor   = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_in_ready", in_ready, 1);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_quotient", quotient, 0);
        check_eq("rst_remainder", remainder, 0);
        check_eq("rst_dbz", div_by_zero, 0);
        check_eq("rst_busy", busy, 0);
        rst_n = 1'b1;

        run_op(16'd100,  16'd7,    16'd14,   16'd2, 1'b0, 16, 0);
        run_op(16'hFFFF, 16'd1,    16'hFFFF, 16'd0, 1'b0, 16, 0);
        run_op(16'hFFFF, 16'hFFFF, 16'd1,    16'd0, 1'b0, 16, 0);
        run_op(16'd3,    16'd10,   16'd0,    16'd3, 1'b0, 16, 0);
        run_op(16'd0,    16'd5,    16'd0,    16'd0, 1'b0, 16, 0);
        run_op(16'd5,    16'd0,    16'hFFFF, 16'd5, 1'b1, 0,  0);
        run_op(16'd1000, 16'd33,   16'd30,   16'd10, 1'b0, 16, 5);
        // Accepted on the cycle right after the previous handshake.
        run_op(16'd20,   16'd6,    16'd3,    16'd2, 1'b0, 16, 0);

        // Reset at RUN iteration 8 of 1234/5.
        in_valid = 1'b1;
        dividend = 16'd1234;
        divisor  = 16'd5;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (7) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check_eq("midrst_in_ready", in_ready, 1);
        check_eq("midrst_out_valid", out_valid, 0);
        check_eq("midrst_quotient", quotient, 0);
        check_eq("midrst_remainder", remainder, 0);
        check_eq("midrst_dbz", div_by_zero, 0);
        check_eq("midrst_busy", busy, 0);
        seen = 1'b0;
        repeat (20) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check_eq("no_stale_result", seen, 0);

        run_op(16'd1234, 16'd5, 16'd246, 16'd4, 1'b0, 16, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
